// File: rtl/mcu_program_loader.sv
// -----------------------------------------------------------------------------
// mcu_program_loader
//
// Host-side writer for the MCU program memory. Accepts opcode/operand pairs
// over a valid/ready handshake, encodes them as {opcode, operand} and writes
// them to consecutive addresses. Optionally pads the tail with NOP (8'h00),
// then reads the program back and compares the read-sum with the running
// checksum. The MCU core is held in reset until a clean verify reaches RUN.
//
// Ports:
//   clk, reset_n          clock (rising edge), synchronous active-low reset
//   start                 pulse; begins a load from IDLE, RUN or ERROR
//   load_valid/ready      word handshake (ready only in LOAD)
//   load_opcode/operand   instruction fields
//   load_last             marks the final program word
//   mem_we/addr/wdata     program memory write port (addr shared with reads)
//   mem_rdata             program memory read data, 1-cycle latency
//   mcu_reset             active-high reset to the MCU core
//   busy/done/error       status: LOAD|PAD|VERIFY / RUN / ERROR
//   error_code            00 none, 01 overflow, 10 verify mismatch
//   word_count, checksum  words accepted and their mod-256 sum
// -----------------------------------------------------------------------------
module mcu_program_loader #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter bit PAD_NOP = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [3:0]        load_opcode,
  input  logic [3:0]        load_operand,
  input  logic              load_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              mcu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        error_code,
  output logic [ADDR_W:0]   word_count,
  output logic [7:0]        checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PAD,
    S_VERIFY,
    S_RUN,
    S_ERROR
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] LAST_W  = DEPTH_W - 1'b1;

  state_t          state_q, state_d;
  logic [ADDR_W:0] word_count_q, word_count_d;
  logic [7:0]      checksum_q, checksum_d;
  logic [ADDR_W:0] addr_q, addr_d;        // pad / verify address counter
  logic [7:0]      read_sum_q, read_sum_d;
  logic            rd_pending_q, rd_pending_d;  // a read was issued last cycle
  logic [1:0]      error_code_q, error_code_d;
  logic            mcu_reset_q;

  logic [7:0]      load_word;
  logic [ADDR_W:0] word_count_inc;
  logic [7:0]      read_sum_now;

  assign load_word      = {load_opcode, load_operand};
  assign word_count_inc = word_count_q + 1'b1;
  // Read data for the address issued last cycle arrives now; fold it in so the
  // drain cycle can compare without an extra register stage.
  assign read_sum_now   = read_sum_q + (rd_pending_q ? mem_rdata : 8'h00);

  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    checksum_d   = checksum_q;
    addr_d       = addr_q;
    read_sum_d   = read_sum_q;
    rd_pending_d = 1'b0;
    error_code_d = error_code_q;
    load_ready   = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = 8'h00;
    busy         = 1'b0;
    done         = 1'b0;
    error        = 1'b0;

    case (state_q)
      S_IDLE, S_RUN, S_ERROR: begin
        done  = (state_q == S_RUN);
        error = (state_q == S_ERROR);
        if (start) begin
          state_d      = S_LOAD;
          word_count_d = '0;
          checksum_d   = 8'h00;
          addr_d       = '0;
          read_sum_d   = 8'h00;
          error_code_d = 2'b00;
        end
      end

      S_LOAD: begin
        busy       = 1'b1;
        load_ready = 1'b1;
        mem_addr   = word_count_q[ADDR_W-1:0];
        mem_wdata  = load_word;
        mem_we     = load_valid;
        if (load_valid) begin
          word_count_d = word_count_inc;
          checksum_d   = checksum_q + load_word;
          if (load_last) begin
            if (PAD_NOP && (word_count_inc < DEPTH_W)) begin
              state_d = S_PAD;
              addr_d  = word_count_inc;
            end else begin
              state_d    = S_VERIFY;
              addr_d     = '0;
              read_sum_d = 8'h00;
            end
          end else if (word_count_q == LAST_W) begin
            // Memory is full and the program has not ended.
            state_d      = S_ERROR;
            error_code_d = 2'b01;
          end
        end
      end

      S_PAD: begin
        busy     = 1'b1;
        mem_we   = 1'b1;
        mem_addr = addr_q[ADDR_W-1:0];
        addr_d   = addr_q + 1'b1;
        if (addr_q == LAST_W) begin
          state_d    = S_VERIFY;
          addr_d     = '0;
          read_sum_d = 8'h00;
        end
      end

      S_VERIFY: begin
        busy       = 1'b1;
        read_sum_d = read_sum_now;
        if (addr_q < word_count_q) begin
          mem_addr     = addr_q[ADDR_W-1:0];
          addr_d       = addr_q + 1'b1;
          rd_pending_d = 1'b1;
        end else begin
          // Drain cycle: last read data is in read_sum_now.
          if (read_sum_now == checksum_q) begin
            state_d = S_RUN;
          end else begin
            state_d      = S_ERROR;
            error_code_d = 2'b10;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      word_count_q <= '0;
      checksum_q   <= 8'h00;
      addr_q       <= '0;
      read_sum_q   <= 8'h00;
      rd_pending_q <= 1'b0;
      error_code_q <= 2'b00;
      mcu_reset_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      checksum_q   <= checksum_d;
      addr_q       <= addr_d;
      read_sum_q   <= read_sum_d;
      rd_pending_q <= rd_pending_d;
      error_code_q <= error_code_d;
      // Registered from the next state so the core sees a clean level that
      // changes exactly on the RUN entry / exit edge.
      mcu_reset_q  <= (state_d != S_RUN);
    end
  end

  assign mcu_reset  = mcu_reset_q;
  assign error_code = error_code_q;
  assign word_count = word_count_q;
  assign checksum   = checksum_q;

endmodule

// File: tb/tb_mcu_program_loader.sv
// -----------------------------------------------------------------------------
// tb_mcu_program_loader
//
// Directed bench for mcu_program_loader with a behavioural program memory
// (1-cycle read latency, optional corruption of address 1 on reads) and a
// write log. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mcu_program_loader;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              load_valid;
  logic              load_ready;
  logic [3:0]        load_opcode;
  logic [3:0]        load_operand;
  logic              load_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mcu_reset;
  logic              busy;
  logic              done;
  logic              error;
  logic [1:0]        error_code;
  logic [ADDR_W:0]   word_count;
  logic [7:0]        checksum;

  always #5 clk = ~clk;

  mcu_program_loader #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .PAD_NOP(1'b1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_opcode (load_opcode),
    .load_operand(load_operand),
    .load_last   (load_last),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mcu_reset   (mcu_reset),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .error_code  (error_code),
    .word_count  (word_count),
    .checksum    (checksum)
  );

  // Program memory model plus write log.
  logic [7:0]        mem [DEPTH];
  bit                corrupt_en = 1'b0;
  logic [ADDR_W-1:0] wlog_addr [$];
  logic [7:0]        wlog_data [$];
  int                done_cnt = 0;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wlog_addr.push_back(mem_addr);
      wlog_data.push_back(mem_wdata);
    end
    mem_rdata <= (corrupt_en && mem_addr == 4'd1) ? 8'h13 : mem[mem_addr];
    if (done) done_cnt <= done_cnt + 1;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Sends every word of w; returns one cycle after the final handshake edge.
  task automatic send_words(input logic [7:0] w[$], input bit last_flag, input bit random_valid);
    int i = 0;
    int guard = 0;
    bit v;
    bit hs;
    logic [7:0] cur;
    while (i < w.size() && guard < 400) begin
      v = random_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      cur = w[i];
      load_valid   = v;
      load_opcode  = cur[7:4];
      load_operand = cur[3:0];
      load_last    = last_flag && (i == w.size() - 1);
      #1;
      hs = v && load_ready;
      @(posedge clk); #1;
      if (hs) i++;
      guard++;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    check_eq("words_accepted", i, w.size());
  endtask

  // Cycles until done (want_done=1) or error (want_done=0), bounded.
  task automatic wait_for(input bit want_done, output int cycles);
    cycles = 0;
    while (!(want_done ? done : error) && cycles < 80) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  // Checks the write log from index base against prog followed by NOP padding.
  task automatic check_writes(input int base, input logic [7:0] prog[$], input int n_exp);
    int n = wlog_addr.size() - base;
    logic [7:0] exp;
    check_eq("write_count", n, n_exp);
    for (int k = 0; k < n && k < n_exp; k++) begin
      exp = (k < prog.size()) ? prog[k] : 8'h00;
      check_eq($sformatf("wr%0d_addr_data", k),
               {20'h0, wlog_addr[base + k], wlog_data[base + k]},
               {20'h0, 4'(k), exp});
    end
  endtask

  initial begin
    logic [7:0] prog [$];
    int base;
    int cyc;
    int dc0;

    reset_n = 1'b0; start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    load_opcode = 4'h0; load_operand = 4'h0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_mcu_reset", mcu_reset, 1);
    check_eq("rst_flags_busy_done_err", {busy, done, error}, 3'b000);
    check_eq("rst_ready_we", {load_ready, mem_we}, 2'b00);
    check_eq("rst_error_code", error_code, 0);
    check_eq("rst_word_count", word_count, 0);
    check_eq("rst_checksum", checksum, 0);
    check_eq("rst_addr_wdata", {mem_addr, mem_wdata}, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_load_ready", load_ready, 0);

    // ---- basic load with padding ----
    prog = '{8'h71, 8'h12, 8'hB0, 8'hF0};
    base = wlog_addr.size();
    pulse_start();
    check_eq("load_busy_ready", {busy, load_ready}, 2'b11);
    send_words(prog, 1'b1, 1'b0);
    check_eq("pad_first_we_addr", {mem_we, mem_addr}, {1'b1, 4'd4});
    wait_for(1'b1, cyc);
    check_eq("basic_run_latency", cyc, 17);
    check_eq("basic_done_mcurst", {done, mcu_reset}, 2'b10);
    check_eq("basic_word_count", word_count, 4);
    check_eq("basic_checksum", checksum, 8'h23);
    check_writes(base, prog, 16);

    // ---- backpressure ----
    prog = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'hF5};
    base = wlog_addr.size();
    pulse_start();
    send_words(prog, 1'b1, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check_eq("verify_busy_ready_we", {busy, load_ready, mem_we}, 3'b100);
    wait_for(1'b1, cyc);
    check_eq("bp_verify_cycles", cyc, 7);
    check_eq("bp_word_count", word_count, 6);
    check_eq("bp_checksum", checksum, 8'hEF);
    check_writes(base, prog, 16);

    // ---- overflow ----
    prog = {};
    for (int k = 0; k < 16; k++) prog.push_back(8'(k * 3 + 1));
    base = wlog_addr.size();
    pulse_start();
    send_words(prog, 1'b0, 1'b0);
    check_eq("ovf_error", {error, busy, done}, 3'b100);
    check_eq("ovf_error_code", error_code, 2'b01);
    check_eq("ovf_mcu_reset", mcu_reset, 1);
    check_eq("ovf_word_count", word_count, 16);
    check_eq("ovf_load_ready", load_ready, 0);
    check_writes(base, prog, 16);

    // ---- verify mismatch ----
    prog = '{8'h71, 8'h12, 8'hB0, 8'hF0};
    corrupt_en = 1'b1;
    dc0 = done_cnt;
    pulse_start();
    check_eq("restart_from_error_code", error_code, 0);
    send_words(prog, 1'b1, 1'b0);
    wait_for(1'b0, cyc);
    corrupt_en = 1'b0;
    check_eq("mis_error_latency", cyc, 17);
    check_eq("mis_error_code", error_code, 2'b10);
    check_eq("mis_mcu_reset", mcu_reset, 1);
    check_eq("mis_done_never", done_cnt - dc0, 0);

    // ---- reset mid-LOAD ----
    prog = '{8'h30, 8'h41};
    pulse_start();
    send_words(prog, 1'b0, 1'b0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check_eq("midrst_word_count", word_count, 0);
    check_eq("midrst_checksum", checksum, 0);
    check_eq("midrst_flags", {mcu_reset, busy, error, load_ready}, 4'b1000);
    prog = '{8'hF0};
    pulse_start();
    send_words(prog, 1'b1, 1'b0);
    wait_for(1'b1, cyc);
    check_eq("one_word_run_latency", cyc, 17);
    check_eq("one_word_count", word_count, 1);
    check_eq("one_word_checksum", checksum, 8'hF0);

    // ---- restart from RUN ----
    check_eq("pre_restart_done", {done, mcu_reset}, 2'b10);
    pulse_start();
    check_eq("restart_mcu_reset", mcu_reset, 1);
    check_eq("restart_busy_ready_done", {busy, load_ready, done}, 3'b110);
    check_eq("restart_counters", {word_count, checksum}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
